// File: rtl/amp_spi_responder.sv
// rtl/amp_spi_responder.sv - SPI gain responder: oversampled receive, readback of held gain word
module amp_spi_responder #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_GAIN = '0
) (
    input  logic               CLK50MHZ,
    input  logic               RST,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    input  logic               amp_cs,
    input  logic               amp_shdn,
    output logic               amp_dout,
    output logic [WIDTH/2-1:0] gain_a,
    output logic [WIDTH/2-1:0] gain_b,
    output logic               gain_update,
    output logic               frame_err
);

    localparam int            HALF     = WIDTH / 2;
    localparam int            CW       = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_nxt;

    // [0],[1] synchronizer stages, [2] history flop for edge detection
    logic [2:0] sck_q, mosi_q, cs_q;

    logic [WIDTH-1:0] gain_q;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [CW-1:0]    bit_cnt;

    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];

    assign gain_b = gain_q[WIDTH-1:HALF];
    assign gain_a = gain_q[HALF-1:0];

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            sck_q  <= '0;
            mosi_q <= '0;
            cs_q   <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            mosi_q <= {mosi_q[1:0], spi_mosi};
            cs_q   <= {cs_q[1:0], amp_cs};
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            gain_q      <= RESET_GAIN;
            shift_reg   <= '0;
            rx_reg      <= '0;
            bit_cnt     <= '0;
            amp_dout    <= 1'b0;
            gain_update <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            gain_update <= 1'b0;
            frame_err   <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    shift_reg <= gain_q;
                    bit_cnt   <= '0;
                    amp_dout  <= gain_q[WIDTH-1];
                end
            end else begin
                // chip-select close takes priority over a coincident sck edge
                if (cs_rise) begin
                    amp_dout <= 1'b0;
                    if (bit_cnt == CNT_FULL) begin
                        gain_update <= 1'b1;
                        gain_q      <= rx_reg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_reg <= {rx_reg[WIDTH-2:0], mosi_q[1]};
                    if (bit_cnt != CNT_MAX) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end else if (sck_fall) begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    amp_dout  <= shift_reg[WIDTH-2];
                end
            end
            // shutdown overrides any frame latch in the same cycle
            if (amp_shdn) begin
                gain_q <= RESET_GAIN;
            end
        end
    end

endmodule

// File: tb/tb_amp_spi_responder.sv
// tb/tb_amp_spi_responder.sv - directed bench for amp_spi_responder
module tb_amp_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n, sck, mosi, cs, shdn;
    logic       dout, upd, ferr;
    logic [3:0] ga, gb;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    always #10 clk = ~clk;

    amp_spi_responder dut (
        .CLK50MHZ    (clk),
        .RST         (rst_n),
        .spi_sck     (sck),
        .spi_mosi    (mosi),
        .amp_cs      (cs),
        .amp_shdn    (shdn),
        .amp_dout    (dout),
        .gain_a      (ga),
        .gain_b      (gb),
        .gain_update (upd),
        .frame_err   (ferr)
    );

    always @(negedge clk) begin
        if (upd)  upd_cnt++;
        if (ferr) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // MSB-first frame of nclk sck periods (12 cycles each); readback sampled before each rise
    task automatic send_frame(input logic [7:0] data, input int nclk,
                              output logic [7:0] rd, output int upd_pos, output int err_pos);
        rd = '0;
        cs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < nclk; i++) begin
            mosi = (i < 8) ? data[7-i] : 1'b0;
            wait_cyc(6);
            if (i < 8) rd[7-i] = dout;
            sck = 1'b1;
            wait_cyc(6);
            sck = 1'b0;
        end
        wait_cyc(4);
        cs = 1'b1;
        upd_pos = 0;
        err_pos = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (upd && upd_pos == 0)  upd_pos = k;
            if (ferr && err_pos == 0) err_pos = k;
        end
    endtask

    logic [7:0] rd;
    int         up, ep;

    initial begin
        rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 1'b1; shdn = 1'b0;
        wait_cyc(5);
        check("rst_gain", 32'({gb, ga}), 'h00);
        rst_n = 1'b1;
        wait_cyc(100);
        check("idle_gain_a", 32'(ga), 'h0);
        check("idle_gain_b", 32'(gb), 'h0);
        check("idle_dout", 32'(dout), 'h0);
        check("idle_upd_cnt", 32'(upd_cnt), 'h0);
        check("idle_err_cnt", 32'(err_cnt), 'h0);

        send_frame(8'h31, 8, rd, up, ep);
        check("w31_readback", 32'(rd), 'h00);
        check("w31_gain_b", 32'(gb), 'h3);
        check("w31_gain_a", 32'(ga), 'h1);
        check("w31_upd_pos", 32'(up), 3);
        check("w31_err_pos", 32'(ep), 0);
        check("w31_upd_cnt", 32'(upd_cnt), 1);

        send_frame(8'hA5, 8, rd, up, ep);
        check("wA5_readback", 32'(rd), 'h31);
        check("wA5_gain", 32'({gb, ga}), 'hA5);
        check("wA5_upd_cnt", 32'(upd_cnt), 2);

        send_frame(8'h0F, 7, rd, up, ep);
        check("short_readback", 32'(rd), 'hA4);
        check("short_err_pos", 32'(ep), 3);
        check("short_upd_pos", 32'(up), 0);
        send_frame(8'h0F, 9, rd, up, ep);
        check("long_readback", 32'(rd), 'hA5);
        check("long_err_pos", 32'(ep), 3);
        check("len_gain", 32'({gb, ga}), 'hA5);
        check("len_err_cnt", 32'(err_cnt), 2);
        check("len_upd_cnt", 32'(upd_cnt), 2);

        shdn = 1'b1;
        wait_cyc(2);
        check("shdn_gain_forced", 32'({gb, ga}), 'h00);
        send_frame(8'h77, 8, rd, up, ep);
        check("shdn_readback", 32'(rd), 'h00);
        check("shdn_upd_pos", 32'(up), 3);
        check("shdn_gain", 32'({gb, ga}), 'h00);
        check("shdn_upd_cnt", 32'(upd_cnt), 3);
        shdn = 1'b0;
        wait_cyc(2);
        send_frame(8'h22, 8, rd, up, ep);
        check("w22_readback", 32'(rd), 'h00);
        check("w22_gain", 32'({gb, ga}), 'h22);
        check("w22_upd_cnt", 32'(upd_cnt), 4);

        // abort after rise, fall, rise, fall; readback of 0x22 is then on bit 5 (=1)
        cs = 1'b0;
        wait_cyc(4);
        mosi = 1'b1;
        wait_cyc(6);
        sck = 1'b1; wait_cyc(6);
        sck = 1'b0; wait_cyc(6);
        sck = 1'b1; wait_cyc(6);
        sck = 1'b0; wait_cyc(4);
        check("abort_dout_pre", 32'(dout), 'h1);
        rst_n = 1'b0;
        #1;
        check("abort_gain", 32'({gb, ga}), 'h00);
        check("abort_dout", 32'(dout), 'h0);
        check("abort_ferr", 32'(ferr), 'h0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(6);
        cs = 1'b1;
        wait_cyc(10);
        check("abort_err_cnt", 32'(err_cnt), 2);
        check("abort_upd_cnt", 32'(upd_cnt), 4);
        check("abort_gain_post", 32'({gb, ga}), 'h00);

        send_frame(8'h12, 8, rd, up, ep);
        check("w12_readback", 32'(rd), 'h00);
        check("w12_gain", 32'({gb, ga}), 'h12);
        check("w12_upd_pos", 32'(up), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
